// File: rtl/vga_controller.sv
// vga_controller: 640x480@60 raster timing generator with a one-stage output register.
// Ports:
//   clk, reset             pixel clock, asynchronous active-high reset
//   i_red/i_green/i_blue   colour returned by the upstream for the current x,y
//   o_request, x, y        combinational pixel request for the current counter position
//   vga_r/g/b              registered colour, forced to 0 while blanked
//   vga_hs, vga_vs         registered active-low syncs
//   vga_blank_n            registered, low during blanking
//   vga_sync_n             constant 0 (no sync-on-green)
module vga_controller #(
    parameter int unsigned WIDTH   = 640,
    parameter int unsigned HEIGHT  = 480,
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 48,
    parameter int unsigned V_FRONT = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                i_red,
    input  logic [7:0]                i_green,
    input  logic [7:0]                i_blue,
    output logic                      o_request,
    output logic [$clog2(WIDTH)-1:0]  x,
    output logic [$clog2(HEIGHT)-1:0] y,
    output logic [7:0]                vga_r,
    output logic [7:0]                vga_g,
    output logic [7:0]                vga_b,
    output logic                      vga_hs,
    output logic                      vga_vs,
    output logic                      vga_blank_n,
    output logic                      vga_sync_n
);

    localparam int unsigned H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HCW     = $clog2(H_TOTAL);
    localparam int unsigned VCW     = $clog2(V_TOTAL);
    localparam int unsigned XW      = $clog2(WIDTH);
    localparam int unsigned YW      = $clog2(HEIGHT);

    // Region boundaries at counter width; sync covers [start, end).
    localparam logic [HCW-1:0] H_LAST  = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT   = HCW'(WIDTH);
    localparam logic [HCW-1:0] H_SS    = HCW'(WIDTH + H_FRONT);
    localparam logic [HCW-1:0] H_SE    = HCW'(WIDTH + H_FRONT + H_SYNC);
    localparam logic [VCW-1:0] V_LAST  = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT   = VCW'(HEIGHT);
    localparam logic [VCW-1:0] V_SS    = VCW'(HEIGHT + V_FRONT);
    localparam logic [VCW-1:0] V_SE    = VCW'(HEIGHT + V_FRONT + V_SYNC);

    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;
    logic           active;
    logic           h_sync;
    logic           v_sync;

    // Raster position: h wraps every line, v advances on the h wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VCW'(1);
        end else begin
            h_cnt <= h_cnt + HCW'(1);
        end
    end

    // Region decode from the current counters.
    always_comb begin
        active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        h_sync = (h_cnt >= H_SS) && (h_cnt < H_SE);
        v_sync = (v_cnt >= V_SS) && (v_cnt < V_SE);
    end

    // Request stage; coordinates are only narrowed while inside the active area.
    always_comb begin
        o_request = active && !reset;
        x         = active ? XW'(h_cnt) : '0;
        y         = active ? YW'(v_cnt) : '0;
    end

    // Pin stage: colour, blank and syncs all sampled from the same counter values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            vga_r       <= active ? i_red   : '0;
            vga_g       <= active ? i_green : '0;
            vga_b       <= active ? i_blue  : '0;
            vga_hs      <= !h_sync;
            vga_vs      <= !v_sync;
            vga_blank_n <= active;
        end
    end

    assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_controller.sv
// tb_vga_controller: checks a full-size and a shrunken raster against a
// cycle-count arithmetic model, with random upstream colour and random resets.
module tb_vga_controller;

    localparam int AW = 640, AH = 480, AHF = 16, AHS = 96, AHB = 48, AVF = 10, AVS = 2, AVB = 33;
    localparam int BW = 8, BH = 8, BHF = 2, BHS = 2, BHB = 2, BVF = 2, BVS = 2, BVB = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a_ir, a_ig, a_ib, b_ir, b_ig, b_ib;
    logic       a_req, b_req;
    logic [9:0] a_x;
    logic [8:0] a_y;
    logic [2:0] b_x, b_y;
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
    logic       a_hs, a_vs, a_bn, a_sn, b_hs, b_vs, b_bn, b_sn;

    vga_controller dut_a (
        .clk(clk), .reset(reset), .i_red(a_ir), .i_green(a_ig), .i_blue(a_ib),
        .o_request(a_req), .x(a_x), .y(a_y), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .vga_hs(a_hs), .vga_vs(a_vs), .vga_blank_n(a_bn), .vga_sync_n(a_sn)
    );

    vga_controller #(
        .WIDTH(BW), .HEIGHT(BH), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB)
    ) dut_b (
        .clk(clk), .reset(reset), .i_red(b_ir), .i_green(b_ig), .i_blue(b_ib),
        .o_request(b_req), .x(b_x), .y(b_y), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .vga_hs(b_hs), .vga_vs(b_vs), .vga_blank_n(b_bn), .vga_sync_n(b_sn)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;          // clock edges since reset release
    bit in_reset = 1'b1;
    int a_blue_prev = 0, b_blue_prev = 0;
    int wa_req, wa_hs, wa_bn, wb_req, wb_hs, wb_vs, wb_bn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got %0h exp %0h", tag, n, got, exp);
        end
    endtask

    // Expected values come from the position p = n mod frame, split into line/pixel.
    task automatic check_inst(input string p, input int w, h, hf, hs, hb, vf, vs, vb,
                              input logic req, input logic [31:0] xg, yg,
                              input logic [7:0] r, g, bb, input logic hsg, vsg, bng, sng,
                              input int blue_prev);
        int ht, vt, fr, hc, vc, hp, vp;
        bit act, actp;
        ht = w + hf + hs + hb;
        vt = h + vf + vs + vb;
        fr = ht * vt;
        check({p, "_sync_n"}, 32'(sng), 32'd0);
        if (in_reset || n == 0) begin
            check({p, "_rst_r"}, 32'(r), 32'd0);
            check({p, "_rst_g"}, 32'(g), 32'd0);
            check({p, "_rst_b"}, 32'(bb), 32'd0);
            check({p, "_rst_hs"}, 32'(hsg), 32'd1);
            check({p, "_rst_vs"}, 32'(vsg), 32'd1);
            check({p, "_rst_blank_n"}, 32'(bng), 32'd0);
        end
        if (in_reset) begin
            check({p, "_rst_request"}, 32'(req), 32'd0);
            return;
        end
        hc = (n % fr) % ht;
        vc = (n % fr) / ht;
        act = (hc < w) && (vc < h);
        check({p, "_request"}, 32'(req), 32'(act));
        check({p, "_x"}, xg, act ? 32'(hc) : 32'd0);
        check({p, "_y"}, yg, act ? 32'(vc) : 32'd0);
        if (n == 0) return;
        hp = ((n - 1) % fr) % ht;
        vp = ((n - 1) % fr) / ht;
        actp = (hp < w) && (vp < h);
        check({p, "_r"}, 32'(r), actp ? 32'(hp % 256) : 32'd0);
        check({p, "_g"}, 32'(g), actp ? 32'(vp % 256) : 32'd0);
        check({p, "_b"}, 32'(bb), actp ? 32'(blue_prev) : 32'd0);
        check({p, "_hs"}, 32'(hsg), 32'(!(hp >= w + hf && hp < w + hf + hs)));
        check({p, "_vs"}, 32'(vsg), 32'(!(vp >= h + vf && vp < h + vf + vs)));
        check({p, "_blank_n"}, 32'(bng), 32'(actp));
    endtask

    task automatic check_all();
        check_inst("a", AW, AH, AHF, AHS, AHB, AVF, AVS, AVB, a_req, 32'(a_x), 32'(a_y),
                   a_r, a_g, a_b, a_hs, a_vs, a_bn, a_sn, a_blue_prev);
        check_inst("b", BW, BH, BHF, BHS, BHB, BVF, BVS, BVB, b_req, 32'(b_x), 32'(b_y),
                   b_r, b_g, b_b, b_hs, b_vs, b_bn, b_sn, b_blue_prev);
    endtask

    // Upstream behaviour: echo x/y as red/green with random blue; 0xFF while blanked.
    task automatic drive();
        if (a_req) begin
            a_ir = a_x[7:0]; a_ig = a_y[7:0]; a_ib = 8'($urandom);
        end else begin
            a_ir = 8'hFF; a_ig = 8'hFF; a_ib = 8'hFF;
        end
        if (b_req) begin
            b_ir = {5'd0, b_x}; b_ig = {5'd0, b_y}; b_ib = 8'($urandom);
        end else begin
            b_ir = 8'hFF; b_ig = 8'hFF; b_ib = 8'hFF;
        end
        a_blue_prev = int'(a_ib);
        b_blue_prev = int'(b_ib);
    endtask

    // Occupancy over the first line of A and the first frame of B.
    task automatic tally();
        if (n < AW + AHF + AHS + AHB) wa_req += int'(a_req);
        if (n >= 1 && n <= AW + AHF + AHS + AHB) begin
            wa_hs += int'(!a_hs);
            wa_bn += int'(a_bn);
        end
        if (n < 196) wb_req += int'(b_req);
        if (n >= 1 && n <= 196) begin
            wb_hs += int'(!b_hs);
            wb_vs += int'(!b_vs);
            wb_bn += int'(b_bn);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!in_reset) n++;
        check_all();
        if (!in_reset) tally();
        drive();
    endtask

    task automatic release_reset();
        reset = 1'b0;
        in_reset = 1'b0;
        n = 0;
        wa_req = 0; wa_hs = 0; wa_bn = 0;
        wb_req = 0; wb_hs = 0; wb_vs = 0; wb_bn = 0;
        #1;
        check_all();
        tally();
        drive();
    endtask

    task automatic mid_reset();
        int hold;
        hold = int'($urandom_range(1, 3));
        #2;
        reset = 1'b1;
        in_reset = 1'b1;
        #1;
        check_all();
        repeat (hold) step();
        release_reset();
    endtask

    initial begin
        a_ir = '0; a_ig = '0; a_ib = '0;
        b_ir = '0; b_ig = '0; b_ib = '0;
        repeat (3) step();
        release_reset();
        repeat (2500) step();
        check("a_line_request_count", 32'(wa_req), 32'd640);
        check("a_line_hs_low_count", 32'(wa_hs), 32'd96);
        check("a_line_blank_n_count", 32'(wa_bn), 32'd640);
        check("b_frame_request_count", 32'(wb_req), 32'd64);
        check("b_frame_hs_low_count", 32'(wb_hs), 32'd28);
        check("b_frame_vs_low_count", 32'(wb_vs), 32'd28);
        check("b_frame_blank_n_count", 32'(wb_bn), 32'd64);
        for (int k = 0; k < 4; k++) begin
            repeat (int'($urandom_range(50, 3000))) step();
            mid_reset();
        end
        repeat (900) step();
        check("b_frame_request_count_after_reset", 32'(wb_req), 32'd64);
        check("a_line_hs_low_count_after_reset", 32'(wa_hs), 32'd96);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_controller.md
Name: vga_controller

Overview:
- Generates 640x480 @ 60 Hz VGA raster timing from a single pixel clock (25.175 MHz nominal, supplied by the board video PLL).
- Issues per-pixel read requests with x/y coordinates to the upstream compositor.
- Registers the returned RGB together with sync and blank, so pixel data and control stay aligned at the DAC/connector pins.

Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync pulse (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync pulse (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- i_red / i_green / i_blue  in  8 each  pixel colour from upstream for the currently requested x,y
- o_request  out  1  high while the counters are in the active region
- x  out  $clog2(WIDTH)  requested pixel column
- y  out  $clog2(HEIGHT)  requested pixel row
- vga_r / vga_g / vga_b  out  8 each  registered colour to the DAC
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- vga_blank_n  out  1  low during blanking
- vga_sync_n  out  1  tied constant 0 (no sync-on-green)

Behaviour:
- Totals: H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK = 800; V_TOTAL = HEIGHT+V_FRONT+V_SYNC+V_BACK = 525.
- h_cnt counts 0..H_TOTAL-1 and increments every clk edge.
  - At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0.
  - Frame = 420000 clocks.
- Horizontal region order: active 0..639, front porch 640..655, sync 656..751, back porch 752..799. Vertical order is the same: active 0..479, front 480..489, sync 490..491, back 492..524.
- Active = (h_cnt < WIDTH) && (v_cnt < HEIGHT).
- Request stage (combinational from counters):
  - o_request = active && !reset.
  - x = active ? h_cnt : 0; y = active ? v_cnt : 0.
- Upstream returns i_red/i_green/i_blue combinationally in the same cycle as the request.
- Output stage: one register stage, latency 1 clock from request to pins. On each clk edge:
  - vga_r/g/b <= active ? i_* : 0
  - vga_blank_n <= active
  - vga_hs <= !(h_cnt in sync region)
  - vga_vs <= !(v_cnt in sync region)
  - All values are taken from the same counter values, so data, blank and sync stay aligned.
- Reset, asynchronous, with immediate effect:
  - h_cnt = v_cnt = 0; vga_r/g/b = 0; vga_hs = 1; vga_vs = 1; vga_blank_n = 0; o_request = 0.
  - First clk edge after deassertion registers pixel (0,0).
  - Reset mid-frame restarts the frame at (0,0); no partial-line recovery.
- vga_hs toggles per line independently of the vertical region (hs pulses continue during vertical blanking).
- Colour inputs outside the active region are ignored; outputs are forced to 0 while blanked.
- No state machine beyond the two counters. Counter widths: $clog2(H_TOTAL) and $clog2(V_TOTAL). Coordinate outputs are truncated to the x/y widths only when active, so no overflow.
- Parameter overrides (e.g. WIDTH=8, HEIGHT=8 for simulation) must scale all region boundaries from the parameters; no hard-coded constants.

Test Plan:
1. Assert reset mid-run -> all outputs immediately at reset values (rgb 0, hs 1, vs 1, blank_n 0, request 0). Release -> next edge shows o_request=1, x=0, y=0.
2. Line timing: count clocks from reset release -> o_request high for 640 consecutive clocks with x 0..639.
   - vga_blank_n high from edge 1 through edge 640.
   - vga_hs low for exactly 96 clocks, starting at registered h_cnt 656; line period 800.
3. Frame timing -> vga_vs low during lines 490-491 (1600 clocks); frame period 420000 clocks; y wraps 479 -> blanking -> 0.
4. Data path: drive i_red = x[7:0], i_green = y[7:0], i_blue = 8'hA5 -> vga_r/g/b equal those values one clock after each request.
   - Pixel (5,3) gives r=5, g=3, b=A5.
   - During blanking, outputs are 0 even with inputs 8'hFF.
5. Mid-frame reset at line 200, pixel 300 -> outputs to reset values within the same cycle. After release, the raster restarts at (0,0) and the full frame period holds again.
6. Small parameters (WIDTH=8, HEIGHT=8, all porches/syncs 2) -> line period 14 and frame period 14*14; request active for 8 clocks on each of the first 8 lines; vga_sync_n = 0 throughout.
